// File: rtl/fb_mem_arbiter.sv
// Frame-buffer SDRAM arbiter: one Avalon-MM master shared by the VGA burst prefetcher (priority)
// and the sprite blitter (single word, starvation guard). All outputs are registered.
module fb_mem_arbiter #(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BURST_W    = 8,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  input  logic [BURST_W-1:0]  vid_len,
  output logic                vid_ack,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic                vid_rvalid,
  output logic                vid_done,
  input  logic                blt_req,
  input  logic                blt_we,
  input  logic [ADDR_W-1:0]   blt_addr,
  input  logic [DATA_W-1:0]   blt_wdata,
  input  logic [DATA_W/8-1:0] blt_be,
  output logic                blt_ack,
  output logic [DATA_W-1:0]   blt_rdata,
  output logic                blt_rvalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [BURST_W-1:0]  m_burstcount,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StVidCmd  = 3'd1,
    StVidData = 3'd2,
    StBltCmd  = 3'd3,
    StBltRd   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [BURST_W-1:0]   word_cnt_q, word_cnt_d;
  logic [STARVE_W-1:0]  starve_q, starve_d, starve_inc;

  logic                 vid_ack_q, vid_ack_d;
  logic [DATA_W-1:0]    vid_rdata_q, vid_rdata_d;
  logic                 vid_rvalid_q, vid_rvalid_d;
  logic                 vid_done_q, vid_done_d;
  logic                 blt_ack_q, blt_ack_d;
  logic [DATA_W-1:0]    blt_rdata_q, blt_rdata_d;
  logic                 blt_rvalid_q, blt_rvalid_d;
  logic [ADDR_W-1:0]    m_address_q, m_address_d;
  logic                 m_read_q, m_read_d;
  logic                 m_write_q, m_write_d;
  logic [DATA_W-1:0]    m_writedata_q, m_writedata_d;
  logic [DATA_W/8-1:0]  m_byteenable_q, m_byteenable_d;
  logic [BURST_W-1:0]   m_burstcount_q, m_burstcount_d;

  // A request seen while its own ack is still visible is the one just served, not a new one.
  logic vid_pending, blt_pending, starved;
  assign vid_pending = vid_req && !vid_ack_q;
  assign blt_pending = blt_req && !blt_ack_q;
  assign starved     = (starve_q == STARVE_W'(STARVE_MAX));
  assign starve_inc  = starved ? starve_q : starve_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    starve_d       = blt_pending ? starve_q : '0;
    vid_ack_d      = 1'b0;
    vid_rdata_d    = vid_rdata_q;
    vid_rvalid_d   = 1'b0;
    vid_done_d     = 1'b0;
    blt_ack_d      = 1'b0;
    blt_rdata_d    = blt_rdata_q;
    blt_rvalid_d   = 1'b0;
    m_address_d    = m_address_q;
    m_read_d       = m_read_q;
    m_write_d      = m_write_q;
    m_writedata_d  = m_writedata_q;
    m_byteenable_d = m_byteenable_q;
    m_burstcount_d = m_burstcount_q;

    unique case (state_q)
      StIdle: begin
        if (blt_pending && (starved || !(vid_pending && vid_len != '0))) begin
          state_d        = StBltCmd;
          starve_d       = '0;
          m_read_d       = !blt_we;
          m_write_d      = blt_we;
          m_address_d    = blt_addr;
          m_writedata_d  = blt_wdata;
          m_byteenable_d = blt_be;
          m_burstcount_d = BURST_W'(1);
        end else if (vid_pending && vid_len != '0) begin
          state_d        = StVidCmd;
          if (blt_pending) starve_d = starve_inc;
          word_cnt_d     = vid_len;
          m_read_d       = 1'b1;
          m_write_d      = 1'b0;
          m_address_d    = vid_addr;
          m_byteenable_d = '1;
          m_burstcount_d = vid_len;
        end else if (vid_pending) begin
          // Zero-length burst: acknowledge and complete without touching the bus.
          vid_ack_d  = 1'b1;
          vid_done_d = 1'b1;
        end
      end
      StVidCmd: begin
        if (blt_pending) starve_d = starve_inc;
        if (!m_waitrequest) begin
          m_read_d  = 1'b0;
          vid_ack_d = 1'b1;
          state_d   = StVidData;
        end
      end
      StVidData: begin
        if (blt_pending) starve_d = starve_inc;
        if (m_readdatavalid) begin
          vid_rdata_d  = m_readdata;
          vid_rvalid_d = 1'b1;
          if (word_cnt_q <= BURST_W'(1)) begin
            word_cnt_d = '0;
            vid_done_d = 1'b1;
            state_d    = StIdle;
          end else begin
            word_cnt_d = word_cnt_q - 1'b1;
          end
        end
      end
      StBltCmd: begin
        if (!m_waitrequest) begin
          blt_ack_d = 1'b1;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = m_read_q ? StBltRd : StIdle;
        end
      end
      StBltRd: begin
        if (m_readdatavalid) begin
          blt_rdata_d  = m_readdata;
          blt_rvalid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= StIdle;
      word_cnt_q     <= '0;
      starve_q       <= '0;
      vid_ack_q      <= 1'b0;
      vid_rdata_q    <= '0;
      vid_rvalid_q   <= 1'b0;
      vid_done_q     <= 1'b0;
      blt_ack_q      <= 1'b0;
      blt_rdata_q    <= '0;
      blt_rvalid_q   <= 1'b0;
      m_address_q    <= '0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= '0;
      m_byteenable_q <= '1;
      m_burstcount_q <= BURST_W'(1);
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      starve_q       <= starve_d;
      vid_ack_q      <= vid_ack_d;
      vid_rdata_q    <= vid_rdata_d;
      vid_rvalid_q   <= vid_rvalid_d;
      vid_done_q     <= vid_done_d;
      blt_ack_q      <= blt_ack_d;
      blt_rdata_q    <= blt_rdata_d;
      blt_rvalid_q   <= blt_rvalid_d;
      m_address_q    <= m_address_d;
      m_read_q       <= m_read_d;
      m_write_q      <= m_write_d;
      m_writedata_q  <= m_writedata_d;
      m_byteenable_q <= m_byteenable_d;
      m_burstcount_q <= m_burstcount_d;
    end
  end

  assign vid_ack      = vid_ack_q;
  assign vid_rdata    = vid_rdata_q;
  assign vid_rvalid   = vid_rvalid_q;
  assign vid_done     = vid_done_q;
  assign blt_ack      = blt_ack_q;
  assign blt_rdata    = blt_rdata_q;
  assign blt_rvalid   = blt_rvalid_q;
  assign m_address    = m_address_q;
  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_writedata  = m_writedata_q;
  assign m_byteenable = m_byteenable_q;
  assign m_burstcount = m_burstcount_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: bursts, stalls, arbitration, starvation, reset mid-burst.
module tb_fb_mem_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        vid_req;
  logic [24:0] vid_addr;
  logic [7:0]  vid_len;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        vid_rvalid;
  logic        vid_done;
  logic        blt_req;
  logic        blt_we;
  logic [24:0] blt_addr;
  logic [15:0] blt_wdata;
  logic [1:0]  blt_be;
  logic        blt_ack;
  logic [15:0] blt_rdata;
  logic        blt_rvalid;
  logic [24:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [15:0] m_writedata;
  logic [1:0]  m_byteenable;
  logic [7:0]  m_burstcount;
  logic        m_waitrequest;
  logic [15:0] m_readdata;
  logic        m_readdatavalid;

  int checks = 0;
  int errors = 0;
  int vid_grants;
  logic granted;
  logic rd_pend;

  fb_mem_arbiter dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .vid_req         (vid_req),
    .vid_addr        (vid_addr),
    .vid_len         (vid_len),
    .vid_ack         (vid_ack),
    .vid_rdata       (vid_rdata),
    .vid_rvalid      (vid_rvalid),
    .vid_done        (vid_done),
    .blt_req         (blt_req),
    .blt_we          (blt_we),
    .blt_addr        (blt_addr),
    .blt_wdata       (blt_wdata),
    .blt_be          (blt_be),
    .blt_ack         (blt_ack),
    .blt_rdata       (blt_rdata),
    .blt_rvalid      (blt_rvalid),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_burstcount    (m_burstcount),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_reset_n   = 1'b0;
    vid_req         = 1'b0;
    vid_addr        = '0;
    vid_len         = '0;
    blt_req         = 1'b0;
    blt_we          = 1'b0;
    blt_addr        = '0;
    blt_wdata       = '0;
    blt_be          = '0;
    m_waitrequest   = 1'b0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1;
    chk("rst_m_read", 32'(m_read), 0);
    chk("rst_m_write", 32'(m_write), 0);
    chk("rst_be", 32'(m_byteenable), 32'h3);
    chk("rst_burst", 32'(m_burstcount), 1);
    chk("rst_addr", 32'(m_address), 0);
    chk("rst_acks", 32'({vid_ack, blt_ack, vid_rvalid, blt_rvalid, vid_done}), 0);
    reset_reset_n = 1'b1;
    step();

    // Video burst of 4
    vid_req = 1'b1; vid_addr = 25'h100; vid_len = 8'd4;
    step();
    chk("vb_read", 32'(m_read), 1);
    chk("vb_addr", 32'(m_address), 32'h100);
    chk("vb_burst", 32'(m_burstcount), 4);
    chk("vb_noack", 32'(vid_ack), 0);
    step();
    chk("vb_ack", 32'(vid_ack), 1);
    chk("vb_read_off", 32'(m_read), 0);
    vid_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 16'hA000 + 16'(i);
      step();
      chk("vb_rvalid", 32'(vid_rvalid), 1);
      chk("vb_rdata", 32'(vid_rdata), 32'hA000 + 32'(i));
      chk("vb_done", 32'(vid_done), (i == 3) ? 1 : 0);
      m_readdatavalid = 1'b0;
      step();
      chk("vb_rvalid_gap", 32'({vid_rvalid, vid_done, vid_ack}), 0);
    end

    // Zero-length video request
    vid_req = 1'b1; vid_len = 8'd0;
    step();
    chk("z_ackdone", 32'({vid_ack, vid_done}), 32'h3);
    chk("z_nobus", 32'({m_read, m_write}), 0);
    vid_req = 1'b0;
    step();
    chk("z_ack_pulse", 32'({vid_ack, vid_done}), 0);

    // Blitter write stalled by waitrequest for 3 cycles
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 25'h20; blt_wdata = 16'hBEEF; blt_be = 2'b01;
    m_waitrequest = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("st_write", 32'(m_write), 1);
      chk("st_read", 32'(m_read), 0);
      chk("st_addr", 32'(m_address), 32'h20);
      chk("st_data", 32'(m_writedata), 32'hBEEF);
      chk("st_be", 32'(m_byteenable), 32'h1);
      chk("st_noack", 32'(blt_ack), 0);
      if (i == 4) m_waitrequest = 1'b0;
    end
    step();
    chk("st_ack", 32'(blt_ack), 1);
    chk("st_write_off", 32'(m_write), 0);
    blt_req = 1'b0;
    step();
    chk("st_ack_pulse", 32'(blt_ack), 0);

    // Simultaneous requests: video first, blitter in the following IDLE cycle
    vid_req = 1'b1; vid_addr = 25'h40; vid_len = 8'd1;
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 25'h55; blt_wdata = 16'h1111; blt_be = 2'b11;
    step();
    chk("sim_vid_first", 32'({m_read, m_write}), 32'h2);
    chk("sim_vaddr", 32'(m_address), 32'h40);
    step();
    chk("sim_vack", 32'(vid_ack), 1);
    vid_req = 1'b0; m_readdatavalid = 1'b1; m_readdata = 16'h5A5A;
    step();
    chk("sim_vdone", 32'({vid_rvalid, vid_done}), 32'h3);
    chk("sim_vrdata", 32'(vid_rdata), 32'h5A5A);
    chk("sim_idle_gap", 32'({m_read, m_write}), 0);
    m_readdatavalid = 1'b0;
    step();
    chk("sim_blt_write", 32'({m_read, m_write}), 32'h1);
    chk("sim_baddr", 32'(m_address), 32'h55);
    chk("sim_bburst", 32'(m_burstcount), 1);
    step();
    chk("sim_back", 32'(blt_ack), 1);
    blt_req = 1'b0;
    step();

    // Blitter read with 5-cycle read latency
    blt_req = 1'b1; blt_we = 1'b0; blt_addr = 25'h7;
    step();
    chk("br_cmd", 32'({m_read, m_write}), 32'h2);
    chk("br_addr", 32'(m_address), 32'h7);
    chk("br_burst", 32'(m_burstcount), 1);
    step();
    chk("br_ack", 32'(blt_ack), 1);
    chk("br_read_off", 32'(m_read), 0);
    blt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("br_wait", 32'(blt_rvalid), 0);
    end
    m_readdatavalid = 1'b1; m_readdata = 16'h1234;
    step();
    chk("br_rvalid", 32'(blt_rvalid), 1);
    chk("br_rdata", 32'(blt_rdata), 32'h1234);
    chk("br_idle", 32'(3'(dut.state_q)), 0);
    m_readdatavalid = 1'b0;
    step();
    chk("br_rvalid_pulse", 32'(blt_rvalid), 0);

    // Starvation: back-to-back len=1 video holds off the blitter for 22 bursts
    vid_req = 1'b1; vid_addr = 25'h80; vid_len = 8'd1;
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 25'h99; blt_wdata = 16'hCAFE; blt_be = 2'b11;
    vid_grants = 0; granted = 1'b0; rd_pend = 1'b0;
    for (int i = 0; i < 300 && !granted; i++) begin
      step();
      m_readdatavalid = rd_pend;
      rd_pend = m_read;
      if (m_write) granted = 1'b1;
      else if (m_read) vid_grants++;
    end
    m_readdatavalid = 1'b0;
    chk("sv_granted", 32'(granted), 1);
    chk("sv_vid_grants", 32'(vid_grants), 22);
    chk("sv_cnt_clear", 32'(dut.starve_q), 0);
    chk("sv_addr", 32'(m_address), 32'h99);
    vid_req = 1'b0;
    step();
    chk("sv_ack", 32'(blt_ack), 1);
    blt_req = 1'b0;
    step();

    // Reset in the middle of an 8-word burst
    vid_req = 1'b1; vid_addr = 25'h200; vid_len = 8'd8;
    step();
    chk("rm_read", 32'(m_read), 1);
    chk("rm_burst", 32'(m_burstcount), 8);
    step();
    chk("rm_ack", 32'(vid_ack), 1);
    vid_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 16'hB000 + 16'(i);
      step();
      chk("rm_rvalid", 32'(vid_rvalid), 1);
      chk("rm_nodone", 32'(vid_done), 0);
    end
    m_readdatavalid = 1'b0;
    reset_reset_n = 1'b0;
    #1;
    chk("rm_clr_rvalid", 32'(vid_rvalid), 0);
    chk("rm_clr_rdata", 32'(vid_rdata), 0);
    chk("rm_clr_burst", 32'(m_burstcount), 1);
    chk("rm_clr_be", 32'(m_byteenable), 32'h3);
    chk("rm_clr_state", 32'(3'(dut.state_q)), 0);
    step();
    reset_reset_n = 1'b1;
    m_readdatavalid = 1'b1; m_readdata = 16'hDEAD;
    step();
    chk("rm_stale", 32'({vid_rvalid, vid_done}), 0);
    m_readdatavalid = 1'b0;
    step();
    chk("rm_stale2", 32'({vid_rvalid, vid_done}), 0);
    vid_req = 1'b1; vid_addr = 25'h300; vid_len = 8'd2;
    step();
    chk("rn_read", 32'(m_read), 1);
    chk("rn_addr", 32'(m_address), 32'h300);
    chk("rn_burst", 32'(m_burstcount), 2);
    step();
    chk("rn_ack", 32'(vid_ack), 1);
    vid_req = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 16'hC001;
    step();
    chk("rn_w0", 32'({vid_rvalid, vid_done}), 32'h2);
    chk("rn_d0", 32'(vid_rdata), 32'hC001);
    m_readdata = 16'hC002;
    step();
    chk("rn_w1", 32'({vid_rvalid, vid_done}), 32'h3);
    chk("rn_d1", 32'(vid_rdata), 32'hC002);
    m_readdatavalid = 1'b0;
    step();
    chk("rn_end", 32'({vid_rvalid, vid_done}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Shares one Avalon-MM master port into frame-buffer SDRAM between two requesters.
- Requester 1: VGA line-prefetch engine, which issues read bursts and has priority.
- Requester 2: sprite blitter, which issues single-word reads/writes and has a starvation guard.
- Sits between the video/blitter logic and the SDRAM controller's slave port inside the SoC fabric.

Parameters:
ADDR_W, 25, word address width on all address ports
DATA_W, 16, data width; byteenable width is DATA_W/8
BURST_W, 8, width of burst length fields; max burst is 2^BURST_W-1 words
STARVE_MAX, 64, consecutive cycles a blitter request may be refused before it is forced through

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
vid_req  in  1  video burst request; level, held until vid_ack
vid_addr  in  ADDR_W  burst start address
vid_len  in  BURST_W  burst length in words
vid_ack  out  1  one-cycle pulse: burst command accepted by memory
vid_rdata  out  DATA_W  returned read word
vid_rvalid  out  1  vid_rdata valid
vid_done  out  1  pulse coincident with last vid_rvalid of a burst
blt_req  in  1  blitter request; level, held until blt_ack
blt_we  in  1  1 = write, 0 = read
blt_addr  in  ADDR_W  word address
blt_wdata  in  DATA_W  write data
blt_be  in  DATA_W/8  byte enables
blt_ack  out  1  one-cycle pulse: command accepted by memory
blt_rdata  out  DATA_W  read data
blt_rvalid  out  1  blt_rdata valid
m_address  out  ADDR_W  Avalon address
m_read  out  1  Avalon read
m_write  out  1  Avalon write
m_writedata  out  DATA_W  Avalon write data
m_byteenable  out  DATA_W/8  Avalon byte enables
m_burstcount  out  BURST_W  Avalon burst count
m_waitrequest  in  1  Avalon waitrequest
m_readdata  in  DATA_W  Avalon read data
m_readdatavalid  in  1  Avalon read data valid

Behaviour:
- States: IDLE, VID_CMD, VID_DATA, BLT_CMD, BLT_RD. All outputs are registered.
- Reset (async, any state): state=IDLE, word/starve counters=0.
  - All outputs 0, except m_byteenable = all ones and m_burstcount = 1.
  - Any m_readdatavalid arriving afterwards while in IDLE is dropped.
- IDLE arbitration is evaluated every IDLE cycle:
  - If starve_cnt == STARVE_MAX and blt_req: grant blitter.
  - Else if vid_req and vid_len != 0: grant video.
  - Else if blt_req: grant blitter.
  - Inputs (addr, len, we, wdata, be) are latched at grant. Command outputs assert the next cycle.
- Zero-length video request: if vid_req and vid_len == 0 in IDLE with no blitter grant, pulse vid_ack and vid_done together next cycle. No bus traffic; stay in IDLE.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each IDLE cycle that blt_req=1 and video is granted.
  - Also increments every cycle spent in VID_CMD/VID_DATA while blt_req=1.
  - Clears on blitter grant or when blt_req=0.
- VID_CMD: m_read=1, m_address, m_burstcount=len held stable.
  - On the cycle m_waitrequest=0: drop m_read next cycle, pulse vid_ack, go to VID_DATA.
- VID_DATA: each m_readdatavalid forwards m_readdata to vid_rdata with vid_rvalid one cycle later, and decrements the word counter.
  - On the last word, vid_done is asserted with that vid_rvalid, and the FSM returns to IDLE.
- BLT_CMD: m_burstcount=1; m_write=blt_we, m_read=!blt_we, with writedata/byteenable from the latch.
  - On m_waitrequest=0: pulse blt_ack, deassert command.
  - Write: go to IDLE. Read: go to BLT_RD.
- BLT_RD: wait for m_readdatavalid. blt_rdata/blt_rvalid follow one cycle later; then IDLE.
- No preemption: a granted transaction always completes.
- Minimum one IDLE cycle between transactions.
- Requester deasserting req before ack is a protocol violation; the latched command still completes.
- m_readdatavalid in any state other than VID_DATA/BLT_RD is ignored.
- Max len 255 words; the counter must not wrap.

Test Plan:
- Video burst: vid_req, addr=0x100, len=4, waitrequest low → m_read one cycle after req, burstcount=4; four vid_rvalid, each one cycle after readdatavalid; vid_done with the 4th.
- Waitrequest stall: blt write addr=0x20, data=0xBEEF, be=2'b01, waitrequest high for 3 cycles → m_write, address, data held 4 cycles; blt_ack pulses once on the accept cycle.
- Simultaneous requests: vid_req and blt_req in the same IDLE cycle, starve_cnt=0 → video served first; blitter granted in the following IDLE cycle.
- Starvation: vid_req held continuously with len=1 and blt_req high → blitter granted once starve_cnt reaches 64; starve_cnt clears on that grant.
- Blitter read: addr=0x7, readdatavalid 5 cycles after accept with data 0x1234 → blt_rvalid=1 and blt_rdata=0x1234 one cycle later; then IDLE.
- Reset mid-burst: reset_reset_n low during VID_DATA (len=8, 3 words returned) → outputs clear immediately; stale readdatavalid after release produces no vid_rvalid; the next vid_req is served normally.
